stream_shifter_arbiter: RTL and testbench

//   Round-robin arbiter sharing one stream_shifter write port among NumReq requesters.

---
 rtl/stream_shifter_arbiter.sv | 168 ++++++++++++++++
 tb/tb_stream_shifter_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_shifter_arbiter.sv
// stream_shifter_arbiter
//   Round-robin arbiter that shares a single stream_shifter write port among
//   NumReq requesters. Each accepted beat is tagged with its source index on
//   sh_wid_o. The block also counts beats that are accepted but not yet popped
//   by the consumer, and stops granting once MaxInflight beats are outstanding.
//
//   Optional feature macro: STREAM_SHIFT_ARB_BURST_EN
//     When defined, a requester keeps priority for up to MaxBurst consecutive
//     beats. When undefined, priority rotates after every accepted beat.
//
// Ports
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   req_i       per-requester beat valid
//   wdata_i     per-requester payload
//   gnt_o       one-hot-or-zero grant, asserted in the cycle the beat is accepted
//   sh_w_o      write strobe to shifter w_i
//   sh_wdata_o  payload to shifter wdata_i
//   sh_wid_o    source index of sh_wdata_o (sideband tag)
//   sh_wok_i    shifter wok_o (ready)
//   sh_rok_i    shifter rok_o (read data valid)
//   sh_r_i      consumer read strobe toward shifter r_i (observed only)
//   inflight_o  beats accepted and not yet popped
//   busy_o      inflight_o != 0
//
// Handshake: a requester raises req_i[i] with wdata_i[i] and holds both stable
// until gnt_o[i] is seen high. A beat moves into the shifter in a cycle where
// sh_w_o (valid) and sh_wok_i (ready) are both high; valid never looks at ready.
// A beat leaves the shifter in a cycle where sh_rok_i and sh_r_i are both high.
module stream_shifter_arbiter #(
  parameter type          data_t      = logic,
  parameter int unsigned  NumReq      = 4,
  parameter int unsigned  MaxInflight = 4,
  parameter int unsigned  MaxBurst    = 4,
  localparam int unsigned IdW         = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned CntW        = $clog2(MaxInflight + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  data_t             wdata_i [NumReq],
  output logic [NumReq-1:0] gnt_o,
  output logic              sh_w_o,
  output data_t             sh_wdata_o,
  output logic [IdW-1:0]    sh_wid_o,
  input  logic              sh_wok_i,
  input  logic              sh_rok_i,
  input  logic              sh_r_i,
  output logic [CntW-1:0]   inflight_o,
  output logic              busy_o
);

  logic [IdW-1:0]      rr_q, rr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdW-1:0]      sel;
  logic                found;
  logic [IdW:0]        sum;
  logic [2*NumReq-1:0] req2;
  logic [NumReq-1:0]   req_rot;
  logic                full, acc, pop;

`ifdef STREAM_SHIFT_ARB_BURST_EN
  localparam int unsigned BW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;
  logic [BW-1:0] burst_q, burst_d, base;
`endif

  // Index following i, wrapping at NumReq-1 (holds at 0 when NumReq==1).
  function automatic logic [IdW-1:0] rr_after(input logic [IdW-1:0] i);
    return (i == IdW'(NumReq - 1)) ? '0 : i + 1'b1;
  endfunction

  // Rotate the request vector so bit 0 is the current priority holder, then
  // take the first set bit and map it back to an absolute index.
  always_comb begin
    req2    = {req_i, req_i};
    req_rot = NumReq'(req2 >> rr_q);
    sel     = rr_q;
    found   = 1'b0;
    sum     = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_q} + (IdW+1)'(k);
        if (sum >= (IdW+1)'(NumReq)) sum = sum - (IdW+1)'(NumReq);
        sel = sum[IdW-1:0];
      end
    end
  end

  // No bypass when full: a pop in the same cycle does not open a slot early.
  assign full       = (cnt_q == CntW'(MaxInflight));
  assign sh_w_o     = (|req_i) & ~full & ~rst_i;
  assign sh_wdata_o = wdata_i[sel];
  assign sh_wid_o   = sel;
  assign acc        = sh_w_o & sh_wok_i;
  assign pop        = sh_rok_i & sh_r_i;
  assign inflight_o = rst_i ? '0 : cnt_q;
  assign busy_o     = |inflight_o;

  always_comb begin
    gnt_o = '0;
    if (acc) gnt_o[sel] = 1'b1;
  end

  // A stray pop with nothing in flight is ignored so the counter cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (acc && !pop)                       cnt_d = cnt_q + 1'b1;
    else if (!acc && pop && cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
`ifdef STREAM_SHIFT_ARB_BURST_EN
    burst_d = burst_q;
    base    = burst_q;
    // Burst owner went idle: end its burst and pass priority on.
    if (burst_q != '0 && !req_i[rr_q]) begin
      base    = '0;
      burst_d = '0;
      rr_d    = rr_after(rr_q);
    end
    if (acc) begin
      if (32'(base) + 32'd1 < MaxBurst) begin
        rr_d    = sel;
        burst_d = base + 1'b1;
      end else begin
        rr_d    = rr_after(sel);
        burst_d = '0;
      end
    end
`else
    if (acc) rr_d = rr_after(sel);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q    <= '0;
      cnt_q   <= '0;
`ifdef STREAM_SHIFT_ARB_BURST_EN
      burst_q <= '0;
`endif
    end else begin
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
`ifdef STREAM_SHIFT_ARB_BURST_EN
      burst_q <= burst_d;
`endif
    end
  end

`ifndef SYNTHESIS
  a_cfg: assert property (@(posedge clk_i)
    (NumReq >= 1) && (MaxInflight >= 1) && (MaxBurst >= 1));

  a_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    pop |-> (cnt_q != '0))
    else $error("stream_shifter_arbiter: pop with no beat in flight");

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_hold
    a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_i[gi] && !gnt_o[gi]) |=> (req_i[gi] && $stable(wdata_i[gi])))
      else $error("stream_shifter_arbiter: requester %0d dropped or changed a pending beat", gi);
  end
`endif

endmodule

// File: tb/tb_stream_shifter_arbiter.sv
module tb_stream_shifter_arbiter;
  localparam int N = 4, MAXI = 4, MB = 4, W = 8;
  typedef logic [W-1:0] data_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0, gnt;
  data_t wdata [N];
  logic sh_w, wok = 1'b0, rok = 1'b0, rd = 1'b0, busy;
  data_t sh_wdata;
  logic [1:0] sh_wid;
  logic [2:0] inflight;

  always #5 clk = ~clk;

  stream_shifter_arbiter #(
    .data_t(logic [W-1:0]), .NumReq(N), .MaxInflight(MAXI), .MaxBurst(MB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wdata_i(wdata), .gnt_o(gnt),
    .sh_w_o(sh_w), .sh_wdata_o(sh_wdata), .sh_wid_o(sh_wid), .sh_wok_i(wok),
    .sh_rok_i(rok), .sh_r_i(rd), .inflight_o(inflight), .busy_o(busy)
  );

  // Scoreboard: beats currently held downstream, as {source, payload}.
  logic [W+1:0] exp_q[$];
  int m_rr = 0, m_burst = 0;
  int n_chk = 0, n_bad = 0;

  logic [N-1:0] e_gnt;
  logic e_w, e_acc, e_pop, e_busy;
  logic [2:0] e_inf;
  int e_sel;
  data_t e_data;
  logic gnt_pend = 1'b0;
  int gnt_idx = 0;

  // Reference: scan from the priority pointer, respect the occupancy limit.
  task automatic model_eval();
    bit found;
    int idx;
    found = 0;
    e_sel = 0;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (!found && req[idx]) begin found = 1; e_sel = idx; end
    end
    e_w    = found && !rst && (exp_q.size() < MAXI);
    e_acc  = e_w && wok;
    e_gnt  = e_acc ? N'(1 << e_sel) : '0;
    e_pop  = rok && rd;
    e_inf  = rst ? 3'd0 : 3'(exp_q.size());
    e_busy = (e_inf != 0);
    e_data = wdata[e_sel];
  endtask

  task automatic model_commit();
`ifdef STREAM_SHIFT_ARB_BURST_EN
    int b;
`endif
    gnt_pend = e_acc;
    gnt_idx  = e_sel;
    if (rst) begin
      exp_q.delete();
      m_rr = 0;
      m_burst = 0;
      return;
    end
    if (e_pop) void'(exp_q.pop_front());
    if (e_acc) exp_q.push_back({2'(e_sel), e_data});
`ifdef STREAM_SHIFT_ARB_BURST_EN
    b = (m_burst != 0 && !req[m_rr]) ? 0 : m_burst;
    if (e_acc) begin
      if (b + 1 < MB) begin m_rr = e_sel; m_burst = b + 1; end
      else begin m_rr = (e_sel + 1) % N; m_burst = 0; end
    end else if (m_burst != 0 && !req[m_rr]) begin
      m_burst = 0;
      m_rr = (m_rr + 1) % N;
    end
`else
    if (e_acc) m_rr = (e_sel + 1) % N;
`endif
  endtask

  // Driver: move to the next negedge; a requester whose beat was granted
  // drops its request and prepares fresh data.
  task automatic next_cycle();
    @(negedge clk);
    if (gnt_pend) begin
      req[gnt_idx]   = 1'b0;
      wdata[gnt_idx] = data_t'($urandom);
      gnt_pend       = 1'b0;
    end
  endtask

  task automatic settle();
    rok = (exp_q.size() != 0);
    #1;
    model_eval();
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && (req != 0 || exp_q.size() != 0); c++) begin
      next_cycle(); rst = 0; wok = 1; rd = 1;
      settle(); model_commit();
    end
  endtask

  task automatic pulse_reset();
    next_cycle(); rst = 1; wok = 1; rd = 0;
    settle(); model_commit();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      next_cycle(); rst = 1; req = '1; wok = 1; rd = 1;
      settle();
      n_chk++;
      if ({gnt, sh_w, inflight, busy} !== 9'b0) begin
        n_bad++;
        $display("FAIL reset c%0d gnt=%b w=%b inf=%0d busy=%b expected all zero", c, gnt, sh_w, inflight, busy);
      end
      model_commit();
    end
  endtask

  task automatic test_rr_all();
    logic [N-1:0] tab [5];
    tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int c = 0; c < 5; c++) begin
      next_cycle(); rst = 0; req = '1; wok = 1; rd = 1;
      settle();
      n_chk++;
      if ({gnt, sh_w, inflight, busy} !== {e_gnt, e_w, e_inf, e_busy}) begin
        n_bad++;
        $display("FAIL rr_all c%0d gnt=%b w=%b inf=%0d busy=%b expected %b %b %0d %b", c, gnt, sh_w, inflight, busy, e_gnt, e_w, e_inf, e_busy);
      end
      if (e_w) begin
        n_chk++;
        if ({sh_wid, sh_wdata} !== {2'(e_sel), e_data}) begin
          n_bad++;
          $display("FAIL rr_all_tag c%0d wid=%0d data=%h expected %0d %h", c, sh_wid, sh_wdata, e_sel, e_data);
        end
      end
`ifndef STREAM_SHIFT_ARB_BURST_EN
      n_chk++;
      if (gnt !== tab[c] || sh_wid !== 2'(c % N)) begin
        n_bad++;
        $display("FAIL rr_all_seq c%0d gnt=%b wid=%0d expected %b %0d", c, gnt, sh_wid, tab[c], c % N);
      end
`endif
      model_commit();
    end
    drain();
  endtask

  task automatic test_wrap();
    logic [N-1:0] set_req [3];
    logic [N-1:0] tab [3];
    set_req = '{4'b0010, 4'b0011, 4'b0000};
    tab     = '{4'b0010, 4'b0001, 4'b0010};
    pulse_reset();
    for (int c = 0; c < 3; c++) begin
      next_cycle(); rst = 0; req |= set_req[c]; wok = 1; rd = 1;
      settle();
      n_chk++;
      if ({gnt, sh_w, inflight, busy} !== {e_gnt, e_w, e_inf, e_busy}) begin
        n_bad++;
        $display("FAIL wrap c%0d gnt=%b w=%b inf=%0d busy=%b expected %b %b %0d %b", c, gnt, sh_w, inflight, busy, e_gnt, e_w, e_inf, e_busy);
      end
`ifndef STREAM_SHIFT_ARB_BURST_EN
      n_chk++;
      if (gnt !== tab[c]) begin
        n_bad++;
        $display("FAIL wrap_seq c%0d gnt=%b expected %b", c, gnt, tab[c]);
      end
`endif
      model_commit();
    end
    drain();
  endtask

  task automatic test_full();
    for (int c = 0; c < 8; c++) begin
      next_cycle(); rst = 0; req |= 4'b0001; wok = 1; rd = (c == 6);
      settle();
      n_chk++;
      if ({gnt, sh_w, inflight, busy} !== {e_gnt, e_w, e_inf, e_busy}) begin
        n_bad++;
        $display("FAIL full c%0d gnt=%b w=%b inf=%0d busy=%b expected %b %b %0d %b", c, gnt, sh_w, inflight, busy, e_gnt, e_w, e_inf, e_busy);
      end
      if (c >= 4 && c <= 6) begin
        n_chk++;
        if (sh_w !== 1'b0 || gnt !== 4'b0 || inflight !== 3'd4) begin
          n_bad++;
          $display("FAIL full_stall c%0d w=%b gnt=%b inf=%0d expected 0 0000 4", c, sh_w, gnt, inflight);
        end
      end
      if (c == 7) begin
        n_chk++;
        if (gnt !== 4'b0001 || inflight !== 3'd3) begin
          n_bad++;
          $display("FAIL full_resume gnt=%b inf=%0d expected 0001 3", gnt, inflight);
        end
      end
      model_commit();
    end
    drain();
  endtask

  task automatic test_acc_pop();
    for (int c = 0; c < 4; c++) begin
      next_cycle(); rst = 0; wok = 1;
      if (c < 3) req |= 4'b0001;
      rd = (c == 2);
      settle();
      n_chk++;
      if ({gnt, sh_w, inflight, busy} !== {e_gnt, e_w, e_inf, e_busy}) begin
        n_bad++;
        $display("FAIL acc_pop c%0d gnt=%b w=%b inf=%0d busy=%b expected %b %b %0d %b", c, gnt, sh_w, inflight, busy, e_gnt, e_w, e_inf, e_busy);
      end
      if (c >= 2) begin
        n_chk++;
        if (inflight !== 3'd2) begin
          n_bad++;
          $display("FAIL acc_pop_cnt c%0d inf=%0d expected 2", c, inflight);
        end
      end
      model_commit();
    end
    drain();
  endtask

  task automatic test_wok_stall();
    for (int c = 0; c < 4; c++) begin
      next_cycle(); rst = 0; req |= 4'b0100; wok = (c == 3); rd = 1;
      settle();
      n_chk++;
      if ({gnt, sh_w, inflight, busy} !== {e_gnt, e_w, e_inf, e_busy}) begin
        n_bad++;
        $display("FAIL wok_stall c%0d gnt=%b w=%b inf=%0d busy=%b expected %b %b %0d %b", c, gnt, sh_w, inflight, busy, e_gnt, e_w, e_inf, e_busy);
      end
      n_chk++;
      if (sh_w !== 1'b1 || sh_wid !== 2'd2 || gnt !== ((c == 3) ? 4'b0100 : 4'b0000)) begin
        n_bad++;
        $display("FAIL wok_stall_out c%0d w=%b wid=%0d gnt=%b", c, sh_w, sh_wid, gnt);
      end
      model_commit();
    end
    drain();
  endtask

`ifdef STREAM_SHIFT_ARB_BURST_EN
  task automatic test_burst();
    int tab [9];
    tab = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    pulse_reset();
    for (int c = 0; c < 9; c++) begin
      next_cycle(); rst = 0; req |= 4'b0011; wok = 1; rd = 1;
      settle();
      n_chk++;
      if (gnt !== N'(1 << tab[c]) || gnt !== e_gnt) begin
        n_bad++;
        $display("FAIL burst c%0d gnt=%b expected index %0d (model %b)", c, gnt, tab[c], e_gnt);
      end
      model_commit();
    end
    drain();
  endtask
`endif

  task automatic test_reset_mid();
`ifdef STREAM_SHIFT_ARB_BURST_EN
    int pre = 5;
`else
    int pre = 1;
`endif
    pulse_reset();
    for (int c = 0; c < pre + 2; c++) begin
      next_cycle(); req |= 4'b0011; wok = 1; rd = 1; rst = (c == pre);
      settle();
      n_chk++;
      if ({gnt, sh_w, inflight, busy} !== {e_gnt, e_w, e_inf, e_busy}) begin
        n_bad++;
        $display("FAIL reset_mid c%0d gnt=%b w=%b inf=%0d busy=%b expected %b %b %0d %b", c, gnt, sh_w, inflight, busy, e_gnt, e_w, e_inf, e_busy);
      end
      if (c == pre + 1) begin
        n_chk++;
        if (gnt !== 4'b0001 || inflight !== 3'd0) begin
          n_bad++;
          $display("FAIL reset_mid_after gnt=%b inf=%0d expected 0001 0", gnt, inflight);
        end
      end
      model_commit();
    end
    rst = 0;
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i]   = 1'b1;
          wdata[i] = data_t'($urandom);
        end
      end
      wok = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 99) == 0);
      settle();
      n_chk++;
      if ({gnt, sh_w, inflight, busy} !== {e_gnt, e_w, e_inf, e_busy}) begin
        n_bad++;
        $display("FAIL random c%0d gnt=%b w=%b inf=%0d busy=%b expected %b %b %0d %b", c, gnt, sh_w, inflight, busy, e_gnt, e_w, e_inf, e_busy);
      end
      if (e_w) begin
        n_chk++;
        if ({sh_wid, sh_wdata} !== {2'(e_sel), e_data}) begin
          n_bad++;
          $display("FAIL random_tag c%0d wid=%0d data=%h expected %0d %h", c, sh_wid, sh_wdata, e_sel, e_data);
        end
      end
      model_commit();
    end
    rst = 0;
    drain();
  endtask

  initial begin
    for (int i = 0; i < N; i++) wdata[i] = data_t'($urandom);
    repeat (2) @(posedge clk);
    test_reset();
    test_rr_all();
    test_wrap();
    test_full();
    test_acc_pop();
    test_wok_stall();
`ifdef STREAM_SHIFT_ARB_BURST_EN
    test_burst();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
